// File: rtl/keypad_time_entry_pkg.sv
// Shared key codes, FSM state encoding and key classification for the keypad time-entry stage.
// Pure declarations: no clocked logic.
package keypad_time_entry_pkg;

  localparam logic [3:0] KEY_START = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_PAUSE = 3'd4
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_time_entry_key_edge_detect.sv
// Turns a level key_valid into a one-cycle accept strobe with the key code captured on that edge.
// Latency 1 cycle; a key held down produces a single strobe.
module key_edge_detect (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       accept,
  output logic [3:0] code
);

  logic key_valid_q;
  logic rise;

  assign rise = key_valid & ~key_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid_q <= 1'b0;
      accept      <= 1'b0;
      code        <= 4'd0;
    end else begin
      key_valid_q <= key_valid;
      accept      <= rise;
      if (rise) code <= key_code;
    end
  end

endmodule

// File: rtl/keypad_time_entry.sv
// Keypad front end for the MM:SS BCD down-counter chain: digit entry, START validation, load/run/pause/clear control.
// FSM acts one cycle after a key edge is registered; all control outputs are registered.
module keypad_time_entry
  import keypad_time_entry_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           key_code,
  input  logic                 key_valid,
  input  logic                 door_closed,
  input  logic                 timer_done,
  output logic [4*NDIGITS-1:0] data_out,
  output logic                 load,
  output logic                 run,
  output logic                 clear_n,
  output logic                 done,
  output logic                 entry_err,
  output logic [2:0]           state_o
);

  localparam int W  = 4 * NDIGITS;
  localparam int CW = $clog2(NDIGITS + 1);

  logic          accept;
  logic [3:0]    code;
  state_t        state_q, state_d;
  logic [W-1:0]  digits_q, digits_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clear_n_d, done_d, err_d;
  logic          start_bad;

  key_edge_detect u_key_edge (
    .clk       (clk),
    .reset     (reset),
    .key_code  (key_code),
    .key_valid (key_valid),
    .accept    (accept),
    .code      (code)
  );

  // Seconds tens lives in digit 1 and must be a valid 0-5 value.
  assign start_bad = ~door_closed || (digits_q == '0) || (digits_q[7:4] > 4'd5);

  always_comb begin
    state_d   = state_q;
    digits_d  = digits_q;
    cnt_d     = cnt_q;
    clear_n_d = 1'b1;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && is_digit(code)) begin
          digits_d = {digits_q[W-5:0], code};
          cnt_d    = CW'(1);
          state_d  = ST_ENTRY;
        end else if (accept && code == KEY_CLEAR) begin
          clear_n_d = 1'b0;
        end
      end
      ST_ENTRY: begin
        if (accept && is_digit(code)) begin
          if (cnt_q < CW'(NDIGITS)) begin
            digits_d = {digits_q[W-5:0], code};
            cnt_d    = cnt_q + CW'(1);
          end
        end else if (accept && code == KEY_CLEAR) begin
          digits_d  = '0;
          cnt_d     = '0;
          clear_n_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (accept && code == KEY_START) begin
          if (start_bad) err_d = 1'b1;
          else           state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: begin
        if (timer_done) begin
          done_d   = 1'b1;
          digits_d = '0;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else if (!door_closed || (accept && code == KEY_CLEAR)) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (accept && code == KEY_START) begin
          if (door_closed) state_d = ST_RUN;
          else             err_d = 1'b1;
        end else if (accept && code == KEY_CLEAR) begin
          digits_d  = '0;
          cnt_d     = '0;
          clear_n_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      digits_q  <= '0;
      cnt_q     <= '0;
      load      <= 1'b0;
      run       <= 1'b0;
      clear_n   <= 1'b1;
      done      <= 1'b0;
      entry_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      cnt_q     <= cnt_d;
      load      <= (state_d == ST_LOAD);
      run       <= (state_d == ST_RUN);
      clear_n   <= clear_n_d;
      done      <= done_d;
      entry_err <= err_d;
    end
  end

  assign data_out = digits_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_keypad_time_entry.sv
// Directed, table-driven bench for keypad_time_entry plus hand sequences for held keys and resets.
module tb_keypad_time_entry;
  import keypad_time_entry_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        door_closed;
  logic        timer_done;
  logic [15:0] data_out;
  logic        load, run, clear_n, done, entry_err;
  logic [2:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;

  keypad_time_entry #(.NDIGITS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .door_closed (door_closed),
    .timer_done  (timer_done),
    .data_out    (data_out),
    .load        (load),
    .run         (run),
    .clear_n     (clear_n),
    .done        (done),
    .entry_err   (entry_err),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        press;
    logic [3:0]  key;
    logic        door;
    logic        tdone;
    logic [15:0] data;
    logic        ld, rn, clr_n, dn, err;
    logic [2:0]  st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic press, logic [3:0] key, logic door, logic tdone,
                              logic [15:0] data, logic ld, logic rn, logic clr_n,
                              logic dn, logic err, logic [2:0] st);
    vec_t v;
    v.press = press; v.key = key; v.door = door; v.tdone = tdone;
    v.data = data; v.ld = ld; v.rn = rn; v.clr_n = clr_n;
    v.dn = dn; v.err = err; v.st = st;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Rising edge, release, then the FSM reaction is visible.
  task automatic press(input logic [3:0] k);
    key_code  = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".data"},    data_out,  16'h0000);
    chk({tag, ".load"},    16'(load),      16'd0);
    chk({tag, ".run"},     16'(run),       16'd0);
    chk({tag, ".clear_n"}, 16'(clear_n),   16'd1);
    chk({tag, ".done"},    16'(done),      16'd0);
    chk({tag, ".err"},     16'(entry_err), 16'd0);
    chk({tag, ".state"},   16'(state_o),   16'(ST_IDLE));
  endtask

  initial begin
    reset = 1'b1; key_code = 4'd0; key_valid = 1'b0; door_closed = 1'b1; timer_done = 1'b0;
    //              press key    door tdone data      ld rn cl dn er state
    vecs.push_back(mk(1, 4'h1, 1, 0, 16'h0001, 0, 0, 1, 0, 0, ST_ENTRY));
    vecs.push_back(mk(1, 4'h3, 1, 0, 16'h0013, 0, 0, 1, 0, 0, ST_ENTRY));
    vecs.push_back(mk(1, 4'h0, 1, 0, 16'h0130, 0, 0, 1, 0, 0, ST_ENTRY));
    vecs.push_back(mk(1, 4'hA, 1, 0, 16'h0130, 1, 0, 1, 0, 0, ST_LOAD));
    vecs.push_back(mk(0, 4'h0, 1, 0, 16'h0130, 0, 1, 1, 0, 0, ST_RUN));
    vecs.push_back(mk(0, 4'h0, 1, 0, 16'h0130, 0, 1, 1, 0, 0, ST_RUN));
    vecs.push_back(mk(1, 4'h5, 1, 0, 16'h0130, 0, 1, 1, 0, 0, ST_RUN));
    vecs.push_back(mk(0, 4'h0, 0, 0, 16'h0130, 0, 0, 1, 0, 0, ST_PAUSE));
    vecs.push_back(mk(1, 4'hA, 1, 0, 16'h0130, 0, 1, 1, 0, 0, ST_RUN));
    vecs.push_back(mk(0, 4'h0, 0, 1, 16'h0000, 0, 0, 1, 1, 0, ST_IDLE));
    vecs.push_back(mk(0, 4'h0, 1, 0, 16'h0000, 0, 0, 1, 0, 0, ST_IDLE));
    vecs.push_back(mk(1, 4'h9, 1, 0, 16'h0009, 0, 0, 1, 0, 0, ST_ENTRY));
    vecs.push_back(mk(1, 4'h9, 1, 0, 16'h0099, 0, 0, 1, 0, 0, ST_ENTRY));
    vecs.push_back(mk(1, 4'h9, 1, 0, 16'h0999, 0, 0, 1, 0, 0, ST_ENTRY));
    vecs.push_back(mk(1, 4'h9, 1, 0, 16'h9999, 0, 0, 1, 0, 0, ST_ENTRY));
    vecs.push_back(mk(1, 4'h9, 1, 0, 16'h9999, 0, 0, 1, 0, 0, ST_ENTRY));
    vecs.push_back(mk(1, 4'hA, 1, 0, 16'h9999, 0, 0, 1, 0, 1, ST_ENTRY));
    vecs.push_back(mk(0, 4'h0, 1, 0, 16'h9999, 0, 0, 1, 0, 0, ST_ENTRY));
    vecs.push_back(mk(1, 4'hB, 1, 0, 16'h0000, 0, 0, 0, 0, 0, ST_IDLE));
    vecs.push_back(mk(0, 4'h0, 1, 0, 16'h0000, 0, 0, 1, 0, 0, ST_IDLE));
    vecs.push_back(mk(1, 4'h0, 1, 0, 16'h0000, 0, 0, 1, 0, 0, ST_ENTRY));
    vecs.push_back(mk(1, 4'hA, 1, 0, 16'h0000, 0, 0, 1, 0, 1, ST_ENTRY));
    vecs.push_back(mk(1, 4'h2, 1, 0, 16'h0002, 0, 0, 1, 0, 0, ST_ENTRY));
    vecs.push_back(mk(1, 4'hA, 0, 0, 16'h0002, 0, 0, 1, 0, 1, ST_ENTRY));
    vecs.push_back(mk(1, 4'hC, 1, 0, 16'h0002, 0, 0, 1, 0, 0, ST_ENTRY));
    vecs.push_back(mk(1, 4'hA, 1, 0, 16'h0002, 1, 0, 1, 0, 0, ST_LOAD));
    vecs.push_back(mk(0, 4'h0, 1, 1, 16'h0002, 0, 1, 1, 0, 0, ST_RUN));
    vecs.push_back(mk(1, 4'hB, 1, 0, 16'h0002, 0, 0, 1, 0, 0, ST_PAUSE));
    vecs.push_back(mk(1, 4'hA, 0, 0, 16'h0002, 0, 0, 1, 0, 1, ST_PAUSE));
    vecs.push_back(mk(1, 4'hB, 1, 0, 16'h0000, 0, 0, 0, 0, 0, ST_IDLE));
    vecs.push_back(mk(0, 4'h0, 1, 0, 16'h0000, 0, 0, 1, 0, 0, ST_IDLE));
    vecs.push_back(mk(1, 4'hB, 1, 0, 16'h0000, 0, 0, 0, 0, 0, ST_IDLE));
    vecs.push_back(mk(0, 4'h0, 1, 0, 16'h0000, 0, 0, 1, 0, 0, ST_IDLE));

    repeat (2) tick();
    reset = 1'b0;
    chk_reset_vals("reset");

    foreach (vecs[i]) begin
      door_closed = vecs[i].door;
      timer_done  = vecs[i].tdone;
      if (vecs[i].press) press(vecs[i].key);
      else               tick();
      chk($sformatf("v%0d.data", i),    data_out,            vecs[i].data);
      chk($sformatf("v%0d.load", i),    16'(load),           16'(vecs[i].ld));
      chk($sformatf("v%0d.run", i),     16'(run),            16'(vecs[i].rn));
      chk($sformatf("v%0d.clear_n", i), 16'(clear_n),        16'(vecs[i].clr_n));
      chk($sformatf("v%0d.done", i),    16'(done),           16'(vecs[i].dn));
      chk($sformatf("v%0d.err", i),     16'(entry_err),      16'(vecs[i].err));
      chk($sformatf("v%0d.state", i),   16'(state_o),        16'(vecs[i].st));
    end
    door_closed = 1'b1;
    timer_done  = 1'b0;

    // Entry 0,4,5 then a one-cycle reset wipes everything; CLEAR afterwards pulses clear_n once.
    press(4'h0);
    press(4'h4);
    press(4'h5);
    chk("seq6.data", data_out, 16'h0045);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_vals("seq6.rst");
    press(4'hB);
    chk("seq6.clr_lo", 16'(clear_n), 16'd0);
    tick();
    chk("seq6.clr_hi", 16'(clear_n), 16'd1);

    // A key held for ten cycles shifts in exactly once.
    key_code  = 4'h5;
    key_valid = 1'b1;
    repeat (10) tick();
    chk("hold.data", data_out, 16'h0005);
    chk("hold.state", 16'(state_o), 16'(ST_ENTRY));
    key_valid = 1'b0;
    repeat (2) tick();
    chk("hold.after", data_out, 16'h0005);
    press(4'hB);
    tick();

    // Reset while running drops run on the sampled edge with no done or clear pulse.
    press(4'h1);
    press(4'hA);
    tick();
    chk("rrun.run", 16'(run), 16'd1);
    reset = 1'b1;
    tick();
    chk("rrun.run_off", 16'(run), 16'd0);
    chk("rrun.done", 16'(done), 16'd0);
    chk("rrun.clear_n", 16'(clear_n), 16'd1);
    chk("rrun.state", 16'(state_o), 16'(ST_IDLE));
    chk("rrun.data", data_out, 16'h0000);
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
